memory_access_unit: RTL and testbench
=====================================

# memory_access_unit

Byte-serial memory access controller between the processor data path and the 512x8 byte-wide data RAM. It accepts one load/store request at a time over the MFA/MFC handshake, decodes access size and signedness from the op3 field, and checks alignment. It then performs 1, 2 or 4 big-endian byte transfers on the RAM port and returns a sign- or zero-extended 32-bit load result.

## Interface
- ADDR_W, 9, byte address width of the RAM port (512 bytes)
- Clk  in  1  clock; all state changes on rising edge
- Clr  in  1  synchronous reset, active-high
- MFA  in  1  memory function activate; requester holds it high until MFC
- ReadWrite  in  1  1 = load, 0 = store; sampled with MFA
- S_memory  in  6  op3 field; [1:0] size (00 word, 01 byte, 10 halfword, 11 doubleword), [3] signed load
- Address  in  ADDR_W  byte address of access; sampled with MFA
- DataIn  in  32  store data; sampled with MFA
- DataOut  out  32  load result, extended to 32 bits; held until the next completed load
- MFC  out  1  memory function complete; one-cycle pulse
- align_err  out  1  high together with MFC when the access was rejected
- ram_addr  out  ADDR_W  RAM byte address
- ram_wdata  out  8  RAM write byte
- ram_we  out  1  RAM write enable
- ram_en  out  1  RAM access enable (read when ram_we = 0)
- ram_rdata  in  8  RAM read byte, valid the cycle after ram_en with ram_we = 0

## Operation
- Reset values: DataOut = 0, MFC = 0, align_err = 0, ram_addr = 0, ram_wdata = 0, ram_we = 0, ram_en = 0. FSM enters IDLE. All outputs are registered.
- FSM states: IDLE, XFER, CAPTURE, DONE, RELEASE.
- IDLE: when MFA = 1, latch Address, ReadWrite, S_memory, DataIn and clear the byte counter k.
  - Misaligned or unsupported access goes to DONE with align_err set and makes no RAM access. This covers halfword with Address[0] = 1, word with Address[1:0] != 0, and size 11 (doubleword).
  - Otherwise set N = 1/2/4 and go to XFER.
- XFER: each cycle drive ram_en = 1, ram_addr = base + k and ram_we = ~rw, then k++. After the cycle with k = N-1, a store goes to DONE and a load goes to CAPTURE.
- Store byte order is big-endian:
  - Byte store writes DataIn[7:0].
  - Halfword store writes DataIn[15:8] at base and [7:0] at base+1.
  - Word store writes [31:24] at base through [7:0] at base+3.
- Load byte order: each ram_rdata is shifted into an assembly register one cycle after its issue. The first byte returned is the most significant.
- CAPTURE: shift in the final byte and deassert ram_en. DataOut is loaded with the assembled value, extended as follows:
  - byte: bits [31:8] = S_memory[3] ? bit 7 : 0
  - halfword: bits [31:16] = S_memory[3] ? bit 15 : 0
  - word: unmodified
- DONE: MFC = 1 for exactly one cycle. align_err = 1 only for a rejected access. ram_en = ram_we = 0. Go to RELEASE.
- RELEASE: wait until MFA = 0, then go to IDLE. This prevents a held MFA from re-triggering.
- Stores and rejected accesses never modify DataOut.
- Address wrap: aligned accesses never cross the 512-byte boundary, so the base + k adder needs no wrap handling. Addition is modulo 2^ADDR_W.
- Clr in any state forces IDLE and reset output values on the next edge. RAM bytes already written by an interrupted store remain written.

## Timing
- T0 is the IDLE cycle that samples MFA = 1. MFC is high in the cycle shown:
  - rejected access: T1
  - byte store: T2
  - halfword store: T3
  - word store: T5
  - byte load: T3
  - halfword load: T4
  - word load: T6
- DataOut is valid in the MFC cycle and stays stable until the next load's CAPTURE edge.
- ram_we and ram_en are high only in XFER cycles, with one byte per cycle and no gaps.
- A new request is accepted no earlier than the first IDLE cycle after MFA was seen low in RELEASE. The minimum request-to-request spacing is therefore the access latency plus 2 cycles.
- Inputs are ignored outside IDLE.

## Test plan
- Word store then load: store 0xDEADBEEF at 0x010, then load word at 0x010. Required: RAM[0x10..0x13] = DE, AD, BE, EF; DataOut = 0xDEADBEEF with MFC at T6; align_err = 0.
- Signed and unsigned byte load: RAM[0x021] = 0x80. LDSB (op3 001001) gives DataOut = 0xFFFFFF80; LDUB (op3 000001) gives 0x00000080; MFC at T3 for each.
- Signed halfword: RAM[0x1FE..0x1FF] = 0x8001. LDSH gives 0xFFFF8001 and LDUH gives 0x00008001; ram_addr reaches 0x1FF with no wrap.
- Misalignment: word load at 0x006 and STH at 0x003. Each gives MFC and align_err = 1 at T1, no ram_en pulse, and DataOut unchanged.
- Handshake hold: keep MFA high for 10 cycles after a byte store. Exactly one write and one MFC pulse occur; a second request is accepted only after MFA drops.
- Reset mid-store: assert Clr at T2 of a word store to 0x040. RAM[0x40..0x41] are written and RAM[0x42..0x43] are untouched. All outputs are 0 next cycle, and the FSM is in IDLE.

Source files
------------

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - byte-serial load/store controller for a 512x8 data RAM
// Big-endian 1/2/4-byte transfers with alignment check and load sign/zero extension.
module memory_access_unit #(
    parameter int ADDR_W = 9
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MFA,
    input  logic              ReadWrite,
    input  logic [5:0]        S_memory,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              align_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    output logic              ram_en,
    input  logic [7:0]        ram_rdata
);

    typedef enum logic [2:0] {IDLE, XFER, CAPTURE, DONE, RELEASE} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] base, base_next;
    logic              rw, rw_next;
    logic              sgn, sgn_next;
    logic [1:0]        last, last_next;
    logic [31:0]       wdata_lat, wdata_lat_next;
    logic [1:0]        k, k_next;
    logic [1:0]        k_inc;
    logic [23:0]       asm_q;
    logic              rd_pend;
    logic [31:0]       assembled;

    logic [31:0]       dout_next;
    logic              mfc_next, err_next, we_next, en_next;
    logic [ADDR_W-1:0] addr_next;
    logic [7:0]        wbyte_next;

    logic              reject;
    logic [1:0]        req_last;
    logic              unused_bits;

    assign unused_bits = ^{S_memory[5:4], S_memory[2]};
    assign k_inc       = k + 2'd1;
    assign assembled   = {asm_q, ram_rdata};

    // last = N-1; size 11 (doubleword) is never supported
    always_comb begin
        req_last = 2'd0;
        reject   = 1'b0;
        case (S_memory[1:0])
            2'b00: begin req_last = 2'd3; reject = (Address[1:0] != 2'b00); end
            2'b01: req_last = 2'd0;
            2'b10: begin req_last = 2'd1; reject = Address[0]; end
            default: reject = 1'b1;
        endcase
    end

    // Byte idx counted from the least significant end of the store word
    function automatic logic [7:0] pick_byte(input logic [31:0] d, input logic [1:0] idx);
        return d[{idx, 3'b000} +: 8];
    endfunction

    always_comb begin
        state_next     = state;
        base_next      = base;
        rw_next        = rw;
        sgn_next       = sgn;
        last_next      = last;
        wdata_lat_next = wdata_lat;
        k_next         = k;
        dout_next      = DataOut;
        mfc_next       = 1'b0;
        err_next       = 1'b0;
        addr_next      = ram_addr;
        wbyte_next     = ram_wdata;
        we_next        = 1'b0;
        en_next        = 1'b0;
        case (state)
            IDLE: begin
                if (MFA) begin
                    base_next      = Address;
                    rw_next        = ReadWrite;
                    sgn_next       = S_memory[3];
                    wdata_lat_next = DataIn;
                    k_next         = 2'd0;
                    if (reject) begin
                        state_next = DONE;
                        mfc_next   = 1'b1;
                        err_next   = 1'b1;
                    end else begin
                        last_next  = req_last;
                        state_next = XFER;
                        en_next    = 1'b1;
                        we_next    = ~ReadWrite;
                        addr_next  = Address;
                        wbyte_next = pick_byte(DataIn, req_last);
                    end
                end
            end
            XFER: begin
                if (k == last) begin
                    state_next = rw ? CAPTURE : DONE;
                    mfc_next   = ~rw;
                end else begin
                    k_next     = k_inc;
                    en_next    = 1'b1;
                    we_next    = ~rw;
                    addr_next  = base + {{(ADDR_W-2){1'b0}}, k_inc};
                    wbyte_next = pick_byte(wdata_lat, last - k_inc);
                end
            end
            CAPTURE: begin
                state_next = DONE;
                mfc_next   = 1'b1;
                case (last)
                    2'd0:    dout_next = {{24{sgn & assembled[7]}}, assembled[7:0]};
                    2'd1:    dout_next = {{16{sgn & assembled[15]}}, assembled[15:0]};
                    default: dout_next = assembled;
                endcase
            end
            DONE: state_next = RELEASE;
            RELEASE: begin
                if (!MFA) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state     <= IDLE;
            base      <= '0;
            rw        <= 1'b0;
            sgn       <= 1'b0;
            last      <= 2'd0;
            wdata_lat <= 32'd0;
            k         <= 2'd0;
            DataOut   <= 32'd0;
            MFC       <= 1'b0;
            align_err <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= 8'd0;
            ram_we    <= 1'b0;
            ram_en    <= 1'b0;
        end else begin
            state     <= state_next;
            base      <= base_next;
            rw        <= rw_next;
            sgn       <= sgn_next;
            last      <= last_next;
            wdata_lat <= wdata_lat_next;
            k         <= k_next;
            DataOut   <= dout_next;
            MFC       <= mfc_next;
            align_err <= err_next;
            ram_addr  <= addr_next;
            ram_wdata <= wbyte_next;
            ram_we    <= we_next;
            ram_en    <= en_next;
        end
    end

    // Read data lags its issue by one cycle, so shift on the cycle after a read
    always_ff @(posedge Clk) begin
        if (Clr) begin
            rd_pend <= 1'b0;
            asm_q   <= 24'd0;
        end else begin
            rd_pend <= ram_en & ~ram_we;
            if (rd_pend) asm_q <= {asm_q[15:0], ram_rdata};
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - self-checking bench for memory_access_unit
// Directed scenarios plus randomized accesses against a byte-array reference model.
module tb_memory_access_unit;

    logic        Clk = 1'b0;
    logic        Clr, MFA, ReadWrite;
    logic [5:0]  S_memory;
    logic [8:0]  Address;
    logic [31:0] DataIn;
    logic [31:0] DataOut;
    logic        MFC, align_err;
    logic [8:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we, ram_en;
    logic [7:0]  ram_rdata;

    memory_access_unit #(.ADDR_W(9)) dut (
        .Clk(Clk), .Clr(Clr), .MFA(MFA), .ReadWrite(ReadWrite), .S_memory(S_memory),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .MFC(MFC),
        .align_err(align_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_en(ram_en), .ram_rdata(ram_rdata)
    );

    always #5 Clk = ~Clk;

    logic [7:0]  mem [512];
    logic [7:0]  model_mem [512];
    int          en_count = 0, we_count = 0, mfc_count = 0;
    logic [8:0]  last_en_addr = 9'd0;
    int          checks = 0, fails = 0;
    logic [31:0] exp_dout = 32'd0;

    always @(posedge Clk) begin
        if (ram_en) begin
            en_count     <= en_count + 1;
            last_en_addr <= ram_addr;
            if (ram_we) begin
                mem[ram_addr] <= ram_wdata;
                we_count      <= we_count + 1;
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
        if (MFC) mfc_count <= mfc_count + 1;
    end

    task automatic access(input logic rw, input logic [5:0] op, input logic [8:0] a,
                          input logic [31:0] d, output int lat, output logic err,
                          output logic [31:0] dout, output int ens);
        int en0;
        en0 = en_count;
        ReadWrite = rw; S_memory = op; Address = a; DataIn = d; MFA = 1'b1;
        lat = -1; err = 1'b0; dout = 32'd0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge Clk); #1;
            if (MFC) begin lat = c; err = align_err; dout = DataOut; break; end
        end
        MFA = 1'b0; Address = 9'($urandom); DataIn = $urandom; ReadWrite = 1'($urandom);
        @(posedge Clk); @(posedge Clk); #1;
        ens = en_count - en0;
    endtask

    // Reference: N bytes big-endian from the base address, latency from access kind
    task automatic model(input logic rw, input logic [5:0] op, input logic [8:0] a,
                         input logic [31:0] d, output int lat, output logic err, output int n);
        logic [31:0] v;
        case (op[1:0])
            2'b01:   n = 1;
            2'b10:   n = 2;
            2'b00:   n = 4;
            default: n = 0;
        endcase
        err = (n == 0) || (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
        if (err) begin
            lat = 1; n = 0;
        end else if (!rw) begin
            for (int j = 0; j < n; j++) model_mem[a + 9'(j)] = 8'(d >> (8 * (n - 1 - j)));
            lat = n + 1;
        end else begin
            v = 32'd0;
            for (int j = 0; j < n; j++) v = (v << 8) | 32'(model_mem[a + 9'(j)]);
            if (op[3] && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
            if (op[3] && n == 2 && v[15]) v = v | 32'hFFFF_0000;
            exp_dout = v;
            lat = n + 2;
        end
    endtask

    task automatic test_reset();
        Clr = 1'b1; MFA = 1'b0; ReadWrite = 1'b0; S_memory = 6'd0; Address = 9'd0; DataIn = 32'd0;
        repeat (3) @(posedge Clk);
        #1;
        checks += 7;
        if (DataOut !== 32'd0) begin fails++; $display("FAIL reset_dataout: got %h expected 0", DataOut); end
        if (MFC !== 1'b0) begin fails++; $display("FAIL reset_mfc: got %b expected 0", MFC); end
        if (align_err !== 1'b0) begin fails++; $display("FAIL reset_align_err: got %b expected 0", align_err); end
        if (ram_addr !== 9'd0) begin fails++; $display("FAIL reset_ram_addr: got %h expected 0", ram_addr); end
        if (ram_wdata !== 8'd0) begin fails++; $display("FAIL reset_ram_wdata: got %h expected 0", ram_wdata); end
        if (ram_we !== 1'b0) begin fails++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        if (ram_en !== 1'b0) begin fails++; $display("FAIL reset_ram_en: got %b expected 0", ram_en); end
        Clr = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic fill_memory();
        int lat, elat, ens, n; logic err, eerr; logic [31:0] dout, d;
        for (int i = 0; i < 128; i++) begin
            d = $urandom;
            model(1'b0, 6'b000100, 9'(4 * i), d, elat, eerr, n);
            access(1'b0, 6'b000100, 9'(4 * i), d, lat, err, dout, ens);
        end
    endtask

    task automatic test_word_store_load();
        int lat, elat, ens, n; logic err, eerr; logic [31:0] dout;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        model(1'b0, 6'b000100, 9'h010, 32'hDEADBEEF, elat, eerr, n);
        access(1'b0, 6'b000100, 9'h010, 32'hDEADBEEF, lat, err, dout, ens);
        checks++;
        if (lat !== 5) begin fails++; $display("FAIL st_word_latency: got %0d expected 5", lat); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (mem[9'h010 + 9'(j)] !== exp_b[j]) begin
                fails++; $display("FAIL st_word_byte%0d: got %h expected %h", j, mem[9'h010 + 9'(j)], exp_b[j]);
            end
        end
        model(1'b1, 6'b000000, 9'h010, 32'd0, elat, eerr, n);
        access(1'b1, 6'b000000, 9'h010, 32'd0, lat, err, dout, ens);
        checks += 3;
        if (lat !== 6) begin fails++; $display("FAIL ld_word_latency: got %0d expected 6", lat); end
        if (dout !== 32'hDEADBEEF) begin fails++; $display("FAIL ld_word_data: got %h expected deadbeef", dout); end
        if (err !== 1'b0) begin fails++; $display("FAIL ld_word_err: got %b expected 0", err); end
    endtask

    task automatic test_byte_sign();
        int lat, elat, ens, n; logic err, eerr; logic [31:0] dout;
        model(1'b0, 6'b000101, 9'h021, 32'h0000_0080, elat, eerr, n);
        access(1'b0, 6'b000101, 9'h021, 32'h0000_0080, lat, err, dout, ens);
        access(1'b1, 6'b001001, 9'h021, 32'd0, lat, err, dout, ens);
        checks += 2;
        if (dout !== 32'hFFFF_FF80) begin fails++; $display("FAIL ldsb_data: got %h expected ffffff80", dout); end
        if (lat !== 3) begin fails++; $display("FAIL ldsb_latency: got %0d expected 3", lat); end
        access(1'b1, 6'b000001, 9'h021, 32'd0, lat, err, dout, ens);
        checks += 2;
        if (dout !== 32'h0000_0080) begin fails++; $display("FAIL ldub_data: got %h expected 00000080", dout); end
        if (lat !== 3) begin fails++; $display("FAIL ldub_latency: got %0d expected 3", lat); end
        model(1'b1, 6'b000001, 9'h021, 32'd0, elat, eerr, n);
    endtask

    task automatic test_half_boundary();
        int lat, elat, ens, n; logic err, eerr; logic [31:0] dout;
        model(1'b0, 6'b000110, 9'h1FE, 32'h0000_8001, elat, eerr, n);
        access(1'b0, 6'b000110, 9'h1FE, 32'h0000_8001, lat, err, dout, ens);
        access(1'b1, 6'b001010, 9'h1FE, 32'd0, lat, err, dout, ens);
        checks += 3;
        if (dout !== 32'hFFFF_8001) begin fails++; $display("FAIL ldsh_data: got %h expected ffff8001", dout); end
        if (lat !== 4) begin fails++; $display("FAIL ldsh_latency: got %0d expected 4", lat); end
        if (last_en_addr !== 9'h1FF) begin fails++; $display("FAIL ldsh_last_addr: got %h expected 1ff", last_en_addr); end
        access(1'b1, 6'b000010, 9'h1FE, 32'd0, lat, err, dout, ens);
        checks += 2;
        if (dout !== 32'h0000_8001) begin fails++; $display("FAIL lduh_data: got %h expected 00008001", dout); end
        if (ens !== 2) begin fails++; $display("FAIL lduh_ram_cycles: got %0d expected 2", ens); end
        model(1'b1, 6'b000010, 9'h1FE, 32'd0, elat, eerr, n);
    endtask

    task automatic test_misalign();
        int lat, ens; logic err; logic [31:0] dout;
        logic [8:0] addrs [2]; logic [5:0] ops [2]; logic rws [2];
        addrs[0] = 9'h006; ops[0] = 6'b000000; rws[0] = 1'b1;
        addrs[1] = 9'h003; ops[1] = 6'b000110; rws[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            access(rws[i], ops[i], addrs[i], 32'hCAFE_F00D, lat, err, dout, ens);
            checks += 4;
            if (lat !== 1) begin fails++; $display("FAIL misalign%0d_latency: got %0d expected 1", i, lat); end
            if (err !== 1'b1) begin fails++; $display("FAIL misalign%0d_err: got %b expected 1", i, err); end
            if (ens !== 0) begin fails++; $display("FAIL misalign%0d_ram_cycles: got %0d expected 0", i, ens); end
            if (dout !== exp_dout) begin fails++; $display("FAIL misalign%0d_dataout: got %h expected %h", i, dout, exp_dout); end
        end
    endtask

    task automatic test_hold();
        int w0, m0, lat, elat, ens, n; logic err, eerr; logic [31:0] dout;
        bit seen;
        w0 = we_count; m0 = mfc_count; seen = 0;
        model(1'b0, 6'b000101, 9'h055, 32'h0000_0055, elat, eerr, n);
        ReadWrite = 1'b0; S_memory = 6'b000101; Address = 9'h055; DataIn = 32'h0000_0055; MFA = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge Clk); #1;
            if (MFC) seen = 1;
        end
        repeat (10) @(posedge Clk);
        #1;
        checks += 3;
        if (!seen) begin fails++; $display("FAIL hold_mfc_seen: got 0 expected 1"); end
        if (we_count - w0 !== 1) begin fails++; $display("FAIL hold_writes: got %0d expected 1", we_count - w0); end
        if (mfc_count - m0 !== 1) begin fails++; $display("FAIL hold_mfc_pulses: got %0d expected 1", mfc_count - m0); end
        MFA = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        model(1'b1, 6'b000001, 9'h055, 32'd0, elat, eerr, n);
        access(1'b1, 6'b000001, 9'h055, 32'd0, lat, err, dout, ens);
        checks += 2;
        if (lat !== 3) begin fails++; $display("FAIL hold_next_latency: got %0d expected 3", lat); end
        if (dout !== 32'h0000_0055) begin fails++; $display("FAIL hold_next_data: got %h expected 00000055", dout); end
    endtask

    task automatic test_reset_mid_store();
        int lat, elat, ens, n; logic err, eerr; logic [31:0] dout;
        ReadWrite = 1'b0; S_memory = 6'b000100; Address = 9'h040; DataIn = 32'h1122_3344; MFA = 1'b1;
        @(posedge Clk); @(posedge Clk); #1;
        Clr = 1'b1;
        @(posedge Clk); #1;
        checks += 5;
        if (DataOut !== 32'd0) begin fails++; $display("FAIL midrst_dataout: got %h expected 0", DataOut); end
        if (MFC !== 1'b0 || align_err !== 1'b0) begin fails++; $display("FAIL midrst_mfc_err: got %b%b expected 00", MFC, align_err); end
        if (ram_en !== 1'b0 || ram_we !== 1'b0) begin fails++; $display("FAIL midrst_en_we: got %b%b expected 00", ram_en, ram_we); end
        if (ram_addr !== 9'd0) begin fails++; $display("FAIL midrst_addr: got %h expected 0", ram_addr); end
        if (ram_wdata !== 8'd0) begin fails++; $display("FAIL midrst_wdata: got %h expected 0", ram_wdata); end
        Clr = 1'b0; MFA = 1'b0; exp_dout = 32'd0;
        model_mem[9'h040] = 8'h11; model_mem[9'h041] = 8'h22;
        @(posedge Clk); #1;
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (mem[9'h040 + 9'(j)] !== model_mem[9'h040 + 9'(j)]) begin
                fails++; $display("FAIL midrst_ram%0d: got %h expected %h", j, mem[9'h040 + 9'(j)], model_mem[9'h040 + 9'(j)]);
            end
        end
        model(1'b1, 6'b000001, 9'h043, 32'd0, elat, eerr, n);
        access(1'b1, 6'b000001, 9'h043, 32'd0, lat, err, dout, ens);
        checks += 2;
        if (lat !== 3) begin fails++; $display("FAIL midrst_idle_latency: got %0d expected 3", lat); end
        if (dout !== exp_dout) begin fails++; $display("FAIL midrst_idle_data: got %h expected %h", dout, exp_dout); end
    endtask

    task automatic test_random();
        int lat, elat, ens, n; logic err, eerr, rw; logic [31:0] dout, d; logic [8:0] a; logic [5:0] op;
        logic [1:0] size;
        for (int i = 0; i < 60; i++) begin
            size = 2'($urandom_range(0, 3));
            rw = 1'($urandom);
            op = {2'b00, 1'($urandom), rw ? 1'b0 : 1'b1, size};
            a = 9'($urandom);
            if ($urandom_range(0, 4) != 0) begin
                if (size == 2'b00) a[1:0] = 2'b00;
                if (size == 2'b10) a[0] = 1'b0;
            end
            d = $urandom;
            model(rw, op, a, d, elat, eerr, n);
            access(rw, op, a, d, lat, err, dout, ens);
            checks += 4;
            if (lat !== elat) begin fails++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, elat); end
            if (err !== eerr) begin fails++; $display("FAIL rnd%0d_err: got %b expected %b", i, err, eerr); end
            if (dout !== exp_dout) begin fails++; $display("FAIL rnd%0d_dataout: got %h expected %h", i, dout, exp_dout); end
            if (ens !== n) begin fails++; $display("FAIL rnd%0d_ram_cycles: got %0d expected %0d", i, ens, n); end
            if (!rw && !eerr) begin
                for (int j = 0; j < n; j++) begin
                    checks++;
                    if (mem[a + 9'(j)] !== model_mem[a + 9'(j)]) begin
                        fails++; $display("FAIL rnd%0d_ram%0d: got %h expected %h", i, j, mem[a + 9'(j)], model_mem[a + 9'(j)]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        fill_memory();
        test_word_store_load();
        test_byte_sign();
        test_half_boundary();
        test_misalign();
        test_hold();
        test_reset_mid_store();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
